// File: rtl/jh_io_pkg.sv
// Shared definitions for the 16-bit init/load/fetch/ack JH hash I/O protocol:
// transfer geometry, host FSM states and the block word-select helper.
package jh_io_pkg;
  localparam int W     = 16;
  localparam int NLD   = 32;
  localparam int NFT   = 16;
  localparam int BLK_W = W * NLD;
  localparam int DIG_W = W * NFT;

  typedef enum logic [2:0] {
    IDLE, INIT, LD_REQ, LD_LOW, FT_REQ, FT_LOW, DONE, ERR
  } state_t;

  // Word 0 is the most significant 16 bits of the block.
  function automatic logic [W-1:0] word_sel(input logic [BLK_W-1:0] blk,
                                            input logic [4:0]       k);
    return blk[(NLD - 1 - int'(k)) * W +: W];
  endfunction
endpackage

// File: rtl/jh_io_if.sv
// Core-side handshake bundle of the JH I/O protocol (host drives requests,
// core wrapper answers with ack and fetch data).
interface jh_io_if;
  import jh_io_pkg::*;

  logic         init;
  logic         load;
  logic         fetch;
  logic [W-1:0] idata;
  logic         ack;
  logic [W-1:0] odata;

  modport master (output init, load, fetch, idata, input ack, odata);
  modport slave  (input init, load, fetch, idata, output ack, odata);
endinterface

// File: rtl/jh_ack_watchdog.sv
// Cycle counter that flags a timeout when the host has waited TMO cycles in
// one handshake state without progress.
module jh_ack_watchdog #(
  parameter int TMO = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic timeout
);
  localparam int CW = $clog2(TMO) + 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      cnt <= '0;
    else if (clr)    cnt <= '0;
    else if (en)     cnt <= cnt + CW'(1);
  end

  assign timeout = en && (cnt == CW'(TMO - 1));
endmodule

// File: rtl/jh_host_master.sv
// Host-side initiator: serialises 512-bit blocks into 32 load transfers and,
// after the last block of a message, fetches the 256-bit digest.
module jh_host_master
  import jh_io_pkg::*;
#(
  parameter int TMO = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              blk_valid,
  output logic              blk_ready,
  input  logic [BLK_W-1:0]  blk_data,
  input  logic              blk_first,
  input  logic              blk_last,
  output logic              dig_valid,
  output logic [DIG_W-1:0]  dig_data,
  output logic              err,
  input  logic              err_clr,
  jh_io_if.master           io
);
  state_t           state, state_d;
  logic [5:0]       wc, wc_d;
  logic [BLK_W-1:0] blk_q;
  logic             last_q;
  logic [DIG_W-1:0] acc;
  logic [W-1:0]     idata_d;
  logic             accept, capture;
  logic             wd_en, wd_clr, timeout;

  assign wd_en  = (state == LD_REQ) || (state == LD_LOW) ||
                  (state == FT_REQ) || (state == FT_LOW);
  assign wd_clr = (state_d != state);

  jh_ack_watchdog #(.TMO(TMO)) u_wd (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (wd_clr),
    .en      (wd_en),
    .timeout (timeout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  // Requests only start from the *_LOW states once ack has been seen low,
  // so a stale ack can never complete a fresh transfer.
  always_comb begin
    state_d = state;
    wc_d    = wc;
    idata_d = io.idata;
    accept  = 1'b0;
    capture = 1'b0;
    unique case (state)
      IDLE: begin
        if (blk_ready && blk_valid) begin
          accept  = 1'b1;
          wc_d    = '0;
          state_d = blk_first ? INIT : LD_LOW;
        end
      end
      INIT: state_d = LD_LOW;
      LD_LOW: begin
        if (timeout) state_d = ERR;
        else if (!io.ack) begin
          if (wc < 6'(NLD)) begin
            idata_d = word_sel(blk_q, wc[4:0]);
            state_d = LD_REQ;
          end else if (last_q) begin
            wc_d    = '0;
            state_d = FT_LOW;
          end else begin
            state_d = IDLE;
          end
        end
      end
      LD_REQ: begin
        if (timeout) state_d = ERR;
        else if (io.ack) begin
          wc_d    = wc + 6'd1;
          state_d = LD_LOW;
        end
      end
      FT_LOW: begin
        if (timeout) state_d = ERR;
        else if (!io.ack) state_d = (wc < 6'(NFT)) ? FT_REQ : DONE;
      end
      FT_REQ: begin
        if (timeout) state_d = ERR;
        else if (io.ack) begin
          capture = 1'b1;
          wc_d    = wc + 6'd1;
          state_d = FT_LOW;
        end
      end
      DONE: state_d = IDLE;
      ERR:  if (err_clr) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Every output is a registered decode of the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blk_ready <= 1'b0;
      dig_valid <= 1'b0;
      err       <= 1'b0;
      io.init   <= 1'b0;
      io.load   <= 1'b0;
      io.fetch  <= 1'b0;
      io.idata  <= '0;
      wc        <= '0;
      blk_q     <= '0;
      last_q    <= 1'b0;
      acc       <= '0;
      dig_data  <= '0;
    end else begin
      blk_ready <= (state_d == IDLE);
      dig_valid <= (state_d == DONE);
      err       <= (state_d == ERR);
      io.init   <= (state_d == INIT);
      io.load   <= (state_d == LD_REQ);
      io.fetch  <= (state_d == FT_REQ);
      io.idata  <= idata_d;
      wc        <= wc_d;
      if (accept) begin
        blk_q  <= blk_data;
        last_q <= blk_last;
      end
      if (capture) acc[int'(wc[3:0]) * W +: W] <= io.odata;
      if (state_d == DONE) dig_data <= acc;
    end
  end
endmodule

// File: doc/jh_host_master.md
Name: jh_host_master

Overview:
- Host-side initiator for the 16-bit init/load/fetch/ack hash I/O protocol.
- Accepts whole 512-bit message blocks and serialises each into 32 load transfers, pulsing init before the first block of a message.
- After the last block, issues 16 fetch transfers and assembles the 256-bit digest.
- Sits between a block-level message source (DMA/padding unit) and the JH I/O wrapper; includes an ack-timeout watchdog.

Parameters:
- W, 16, I/O word width.
- NLD, 32, load transfers per 512-bit block.
- NFT, 16, fetch transfers per 256-bit digest.
- TMO, 1024, cycles to wait for an ack edge before flagging error.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- blk_valid  in  1  message block available.
- blk_ready  out  1  master accepts block this cycle.
- blk_data  in  512  message block; word k = blk_data[511-16k -: 16].
- blk_first  in  1  block is the first of a message; triggers init.
- blk_last  in  1  block is the last of a message; triggers fetch.
- dig_valid  out  1  one-cycle pulse, digest complete.
- dig_data  out  256  digest; fetch word j at dig_data[16j+15:16j]; held until next digest.
- err  out  1  sticky ack timeout.
- err_clr  in  1  clears err, returns FSM to IDLE.
- init  out  1  one-cycle init pulse to the core wrapper.
- load  out  1  load request level.
- fetch  out  1  fetch request level.
- idata  out  16  load word.
- ack  in  1  acknowledge from the core wrapper.
- odata  in  16  fetch word, valid while ack=1.

Behaviour:
- Reset values: all outputs 0, counters 0, FSM in IDLE.
- Reset mid-transfer aborts immediately; no partial digest is emitted.
- All outputs are registered; ack and odata are sampled directly on the clk edge.
- States: IDLE, INIT, LD_REQ, LD_LOW, FT_REQ, FT_LOW, DONE, ERR.
- IDLE:
  - blk_ready=1.
  - On blk_valid: latch blk_data/blk_last, clear word counter wc.
  - Go to INIT if blk_first, else LD_LOW.
- INIT: init=1 for exactly one cycle, then LD_LOW.
- LD_LOW (request inactive):
  - Wait ack=0.
  - Then, if wc<NLD: drive idata=word wc, set load=1, go to LD_REQ.
  - If wc==NLD: go to FT_LOW (wc cleared) if blk_last, else IDLE.
- LD_REQ:
  - Hold load=1 and idata stable until ack=1.
  - On that edge: load<=0, wc<=wc+1, go to LD_LOW.
- Ack already high when a new request would start: master waits in *_LOW; never starts a request on a stale ack.
- FT_LOW: wait ack=0; if wc<NFT, set fetch=1 and go to FT_REQ, else go to DONE.
- FT_REQ:
  - Hold fetch=1. The core may withhold ack for many cycles during finalisation; this is legal.
  - On ack=1: capture odata into dig_data word wc, fetch<=0, wc<=wc+1, go to FT_LOW.
- DONE: dig_valid=1 for one cycle, then IDLE.
- Watchdog:
  - Cycle counter clears on every state change.
  - Counts while in LD_REQ/FT_REQ/LD_LOW/FT_LOW.
  - Reaching TMO: drop load/fetch, set err=1, go to ERR.
- ERR: blk_ready=0; stays until err_clr=1, then err<=0 and IDLE.
- err_clr outside ERR has no effect.
- blk_valid outside IDLE is ignored (blk_ready=0).
- init, load and fetch are mutually exclusive; never more than one high.
- Latency, single-block message with immediate acks:
  - 1 init cycle plus 32×2 load cycles.
  - Then 16×2 fetch cycles plus finalisation stall.
  - Then 1 cycle to dig_valid.

Decomposition:
- Shared package jh_io_pkg:
  - W, NLD, NFT constants.
  - FSM state enum.
  - Word-select helper (index k → bit slice) shared with the wrapper side.
- One natural sub-module, jh_ack_watchdog: counter with clear, enable and TMO compare, emitting a timeout pulse.
- Word counter, block register and digest register stay in the top.

Test Plan:
- Single block: blk_first=blk_last=1, blk_data=512'h0…01; responder acks 2 cycles after each request.
  - init pulses once.
  - Exactly 32 loads; idata of word 31 = 16'h0001.
  - Then 16 fetches; responder returns odata=j+16'hA000.
  - dig_data[15:0]=16'hA000, dig_data[255:240]=16'hA00F, single dig_valid pulse.
- Three-block message: first, middle, last.
  - init only before block 0.
  - 96 loads total; no fetch before block 2 completes.
  - blk_ready low throughout each block.
- Stale ack: hold ack=1 for 5 cycles after an accepted load.
  - Next load is not asserted until ack falls.
  - wc advances by exactly 1.
- Finalisation stall: responder withholds the first fetch ack for 200 cycles (TMO=1024).
  - fetch stays high, no error, digest correct.
- Timeout: responder never acks load word 7.
  - After TMO cycles load=0 and err=1; blk_ready stays 0.
  - err_clr=1 → err=0, IDLE, blk_ready=1.
- Reset asserted during fetch word 9.
  - All outputs 0 asynchronously, no dig_valid.
  - After release, a fresh message completes normally.
